// File: rtl/countdown_timer.sv
// countdown_timer
// BCD M:SS countdown timer for the guess-number game. The game control FSM
// loads the initial time with timer_set and lets the time run with timer_en.
// sec_tick pulses once per counted second. timer_finish pulses once when the
// time reaches 0:00.

module countdown_timer #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int INIT_MIN      = 1,
    parameter int INIT_SEC      = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       timer_set,
    input  logic       timer_en,
    output logic       timer_finish,
    output logic       sec_tick,
    output logic [3:0] min_bcd,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones
);

    localparam int             PW        = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]  LAST_TICK = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]     LOAD_MIN  = 4'(INIT_MIN);
    localparam logic [3:0]     LOAD_TENS = 4'(INIT_SEC / 10);
    localparam logic [3:0]     LOAD_ONES = 4'(INIT_SEC % 10);

    logic [PW-1:0] prescaler;
    logic          at_zero;
    logic [3:0]    dec_min;
    logic [3:0]    dec_tens;
    logic [3:0]    dec_ones;
    logic          dec_zero;

    // Time one second earlier than the current digits, with BCD borrows.
    // This value is only used when the current time is not 0:00, so the
    // minutes digit never underflows.
    always_comb begin
        // NOTE: each combinational output gets a default first, so every path
        // assigns it and no latch is inferred.
        dec_min  = min_bcd;
        dec_tens = sec_tens;
        dec_ones = sec_ones;
        at_zero  = (min_bcd == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
        if (sec_ones != 4'd0) begin
            dec_ones = sec_ones - 4'd1;
        end else begin
            dec_ones = 4'd9;
            if (sec_tens != 4'd0) begin
                dec_tens = sec_tens - 4'd1;
            end else begin
                dec_tens = 4'd5;
                dec_min  = min_bcd - 4'd1;
            end
        end
        dec_zero = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);
    end

    // Load, count, or hold the prescaler and the digits. The pulse outputs
    // are registered here and are high only on the cycle after a wrap.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register here samples values from before the clock edge.
        if (rst || timer_set) begin
            prescaler    <= '0;
            min_bcd      <= LOAD_MIN;
            sec_tens     <= LOAD_TENS;
            sec_ones     <= LOAD_ONES;
            timer_finish <= 1'b0;
            sec_tick     <= 1'b0;
        end else if (timer_en && !at_zero) begin
            if (prescaler == LAST_TICK) begin
                prescaler    <= '0;
                min_bcd      <= dec_min;
                sec_tens     <= dec_tens;
                sec_ones     <= dec_ones;
                sec_tick     <= 1'b1;
                timer_finish <= dec_zero;
            end else begin
                prescaler    <= prescaler + PW'(1);
                sec_tick     <= 1'b0;
                timer_finish <= 1'b0;
            end
        end else begin
            sec_tick     <= 1'b0;
            timer_finish <= 1'b0;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer with TICKS_PER_SEC = 4.
// dut_a starts from 0:03 and dut_b starts from 1:00. Both share the clock
// and the control inputs. Every scenario task drives the stimulus and
// compares the outputs against hand-computed values.

module tb_countdown_timer;

    logic       clk;
    logic       rst;
    logic       timer_set;
    logic       timer_en;

    logic       finish_a, tick_a;
    logic [3:0] min_a, tens_a, ones_a;
    logic       finish_b, tick_b;
    logic [3:0] min_b, tens_b, ones_b;

    logic [11:0] time_a;
    logic [11:0] time_b;
    assign time_a = {min_a, tens_a, ones_a};
    assign time_b = {min_b, tens_b, ones_b};

    int n_checks = 0;
    int n_pass   = 0;

    countdown_timer #(.TICKS_PER_SEC(4), .INIT_MIN(0), .INIT_SEC(3)) dut_a (
        .clk(clk), .rst(rst), .timer_set(timer_set), .timer_en(timer_en),
        .timer_finish(finish_a), .sec_tick(tick_a),
        .min_bcd(min_a), .sec_tens(tens_a), .sec_ones(ones_a)
    );

    countdown_timer #(.TICKS_PER_SEC(4), .INIT_MIN(1), .INIT_SEC(0)) dut_b (
        .clk(clk), .rst(rst), .timer_set(timer_set), .timer_en(timer_en),
        .timer_finish(finish_b), .sec_tick(tick_b),
        .min_bcd(min_b), .sec_tens(tens_b), .sec_ones(ones_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait one rising edge, then sample 1 time unit after that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; timer_set = 1'b0; timer_en = 1'b0;
        step(); step();
        n_checks++;
        if (time_a !== 12'h003) $display("FAIL reset_time_a: got %h expected 003", time_a);
        else n_pass++;
        n_checks++;
        if (time_b !== 12'h100) $display("FAIL reset_time_b: got %h expected 100", time_b);
        else n_pass++;
        n_checks++;
        if ({finish_a, tick_a, finish_b, tick_b} !== 4'b0000)
            $display("FAIL reset_pulses: got %b expected 0000", {finish_a, tick_a, finish_b, tick_b});
        else n_pass++;
    endtask

    // Start from 0:03 and count for 12 enabled cycles.
    task automatic test_countdown();
        logic [11:0] exp_time;
        rst = 1'b1; step();
        rst = 1'b0; timer_en = 1'b1;
        exp_time = 12'h003;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c % 4 == 0) exp_time = exp_time - 12'h001;
            n_checks++;
            if (tick_a !== ((c % 4) == 0))
                $display("FAIL countdown_tick c=%0d: got %b expected %b", c, tick_a, (c % 4) == 0);
            else n_pass++;
            n_checks++;
            if (finish_a !== (c == 12))
                $display("FAIL countdown_finish c=%0d: got %b expected %b", c, finish_a, c == 12);
            else n_pass++;
            n_checks++;
            if (time_a !== exp_time)
                $display("FAIL countdown_time c=%0d: got %h expected %h", c, time_a, exp_time);
            else n_pass++;
        end
    endtask

    // Continue from 0:00 with en high. Then load the initial time with set.
    task automatic test_hold_at_zero();
        for (int c = 0; c < 20; c++) begin
            step();
            n_checks++;
            if ({finish_a, tick_a} !== 2'b00)
                $display("FAIL zero_pulses c=%0d: got %b expected 00", c, {finish_a, tick_a});
            else n_pass++;
            n_checks++;
            if (time_a !== 12'h000)
                $display("FAIL zero_time c=%0d: got %h expected 000", c, time_a);
            else n_pass++;
        end
        timer_set = 1'b1; step();
        timer_set = 1'b0; timer_en = 1'b0;
        n_checks++;
        if (time_a !== 12'h003) $display("FAIL zero_reload_time: got %h expected 003", time_a);
        else n_pass++;
        n_checks++;
        if (finish_a !== 1'b0) $display("FAIL zero_reload_finish: got %b expected 0", finish_a);
        else n_pass++;
    endtask

    // Start from 1:00 on dut_b. Check 0:59, then 0:10, then 0:09.
    task automatic test_borrow();
        rst = 1'b1; step();
        rst = 1'b0; timer_en = 1'b1;
        for (int c = 0; c < 4; c++) step();
        n_checks++;
        if (time_b !== 12'h059) $display("FAIL borrow_059: got %h expected 059", time_b);
        else n_pass++;
        n_checks++;
        if ({tick_b, finish_b} !== 2'b10)
            $display("FAIL borrow_pulses: got %b expected 10", {tick_b, finish_b});
        else n_pass++;
        for (int c = 0; c < 49 * 4; c++) step();
        n_checks++;
        if (time_b !== 12'h010) $display("FAIL borrow_010: got %h expected 010", time_b);
        else n_pass++;
        for (int c = 0; c < 4; c++) step();
        n_checks++;
        if (time_b !== 12'h009) $display("FAIL borrow_009: got %h expected 009", time_b);
        else n_pass++;
    endtask

    // Run 2 cycles, pause for 10 cycles, then resume. The decrement must
    // come after 4 enabled cycles in total.
    task automatic test_pause();
        timer_en = 1'b0;
        rst = 1'b1; step();
        rst = 1'b0; timer_en = 1'b1;
        step(); step();
        timer_en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if (tick_a !== 1'b0) $display("FAIL pause_tick c=%0d: got %b expected 0", c, tick_a);
            else n_pass++;
            n_checks++;
            if (time_a !== 12'h003) $display("FAIL pause_time c=%0d: got %h expected 003", c, time_a);
            else n_pass++;
        end
        timer_en = 1'b1;
        step();
        n_checks++;
        if ({tick_a, time_a} !== {1'b0, 12'h003})
            $display("FAIL resume_3rd: got %b/%h expected 0/003", tick_a, time_a);
        else n_pass++;
        step();
        n_checks++;
        if ({tick_a, time_a} !== {1'b1, 12'h002})
            $display("FAIL resume_4th: got %b/%h expected 1/002", tick_a, time_a);
        else n_pass++;
    endtask

    // Count to 0:01 with the prescaler at 3. Then hold set and en high
    // together for 3 cycles.
    task automatic test_set_priority();
        rst = 1'b1; step();
        rst = 1'b0; timer_en = 1'b1;
        for (int c = 0; c < 11; c++) step();
        n_checks++;
        if (time_a !== 12'h001) $display("FAIL setpri_pre: got %h expected 001", time_a);
        else n_pass++;
        timer_set = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if ({finish_a, tick_a, time_a} !== {2'b00, 12'h003})
                $display("FAIL setpri_load c=%0d: got %b%b/%h expected 00/003", c, finish_a, tick_a, time_a);
            else n_pass++;
        end
        timer_set = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            n_checks++;
            if ({tick_a, time_a} !== ((c == 4) ? {1'b1, 12'h002} : {1'b0, 12'h003}))
                $display("FAIL setpri_after c=%0d: got %b/%h", c, tick_a, time_a);
            else n_pass++;
            n_checks++;
            if (finish_a !== 1'b0) $display("FAIL setpri_finish c=%0d: got %b expected 0", c, finish_a);
            else n_pass++;
        end
    endtask

    // Count to 0:02 and stop in the middle of a second. Assert rst for one
    // cycle and check that the partial second is discarded.
    task automatic test_reset_mid();
        rst = 1'b1; step();
        rst = 1'b0; timer_en = 1'b1;
        for (int c = 0; c < 6; c++) step();
        n_checks++;
        if (time_a !== 12'h002) $display("FAIL rstmid_pre: got %h expected 002", time_a);
        else n_pass++;
        rst = 1'b1; step();
        rst = 1'b0;
        n_checks++;
        if ({finish_a, tick_a, time_a} !== {2'b00, 12'h003})
            $display("FAIL rstmid_load: got %b%b/%h expected 00/003", finish_a, tick_a, time_a);
        else n_pass++;
        for (int c = 1; c <= 4; c++) begin
            step();
            n_checks++;
            if ({tick_a, time_a} !== ((c == 4) ? {1'b1, 12'h002} : {1'b0, 12'h003}))
                $display("FAIL rstmid_after c=%0d: got %b/%h", c, tick_a, time_a);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; timer_set = 1'b0; timer_en = 1'b0;
        test_reset();
        test_countdown();
        test_hold_at_zero();
        test_borrow();
        test_pause();
        test_set_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
